// File: rtl/rv32i_mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register
// offsets inside the 2-word window, STATUS bit positions and FSM states.
package rv32i_mmio_pkg;

  localparam logic [2:0] TXDATA_OFS = 3'd0;
  localparam logic [2:0] STATUS_OFS = 3'd4;

  localparam int ST_FULL      = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_ACTIVE    = 2;
  localparam int ST_OVF       = 3;
  localparam int ST_COUNT_LSB = 4;
  localparam int ST_COUNT_W   = 4;

  localparam int DATA_BITS = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } uartState_t;

  // Assembles the STATUS word; every bit not listed reads as zero.
  function automatic logic [31:0] packStatus(
    input logic                  full,
    input logic                  empty,
    input logic                  active,
    input logic                  ovf,
    input logic [ST_COUNT_W-1:0] count
  );
    logic [31:0] s;
    s = '0;
    s[ST_FULL]   = full;
    s[ST_EMPTY]  = empty;
    s[ST_ACTIVE] = active;
    s[ST_OVF]    = ovf;
    s[ST_COUNT_LSB +: ST_COUNT_W] = count;
    return s;
  endfunction

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Small synchronous FIFO with a combinational head. A push while full is
// still accepted when a pop frees a slot on the same edge.
module sync_fifo
  #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
  )
  (
    input  logic             CLK,
    input  logic             RST,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
  );

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [CW-1:0]    r_count;
  logic             w_doPush;
  logic             w_doPop;

  assign w_doPop  = pop && !empty;
  assign w_doPush = push && (!full || w_doPop);

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + AW'(1);
      if (w_doPop)  r_rdPtr <= r_rdPtr + AW'(1);
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (w_doPush) r_mem[r_wrPtr] <= din;
  end

  assign dout  = r_mem[r_rdPtr];
  assign full  = (r_count == CW'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the CPU store path: TXDATA stores
// are queued in a FIFO and serialised on TX; STATUS is readable and clears overflow.
module mmio_uart_tx
  import rv32i_mmio_pkg::*;
  #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
    parameter int          CLKS_PER_BIT = 4,
    parameter int          FIFO_DEPTH   = 4
  )
  (
    input  logic        CLK,
    input  logic        RST,
    input  logic        MemWrite,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        TX,
    output logic        Busy
  );

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  uartState_t       r_state;
  logic [BW-1:0]    r_baudCnt;
  logic [2:0]       r_bitIdx;
  logic [7:0]       r_shift;
  logic             r_tx;
  logic             r_ovf;

  logic             w_hit;
  logic             w_txHit;
  logic             w_stHit;
  logic             w_push;
  logic             w_pop;
  logic             w_bitEnd;
  logic             w_full;
  logic             w_empty;
  logic [7:0]       w_head;
  logic [CW-1:0]    w_count;
  logic [3:0]       w_count4;
  logic             w_unused;

  // Word-granular decode: bit 2 picks the register, bits 1:0 are don't-care.
  assign w_hit   = (ALUResult[31:3] == BASE_ADDR[31:3]);
  assign w_txHit = w_hit && (ALUResult[2] == TXDATA_OFS[2]);
  assign w_stHit = w_hit && (ALUResult[2] == STATUS_OFS[2]);
  assign w_push  = MemWrite && w_txHit;

  assign w_bitEnd = (r_baudCnt == BW'(CLKS_PER_BIT - 1));

  // The head leaves the FIFO when a frame starts from idle or when a stop
  // bit ends with more data waiting, which keeps back-to-back frames gapless.
  assign w_pop = !w_empty &&
                 ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bitEnd));

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (w_push),
    .pop   (w_pop),
    .din   (WriteData[7:0]),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  // Overflow is sticky: a dropped byte sets it, only a STATUS write clears it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ovf <= 1'b0;
    end else if (w_push && w_full && !w_pop) begin
      r_ovf <= 1'b1;
    end else if (MemWrite && w_stHit && WriteData[ST_OVF]) begin
      r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_baudCnt <= '0;
      r_bitIdx  <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx      <= 1'b1;
          r_baudCnt <= '0;
          if (!w_empty) begin
            r_shift <= w_head;
            r_state <= S_START;
            r_tx    <= 1'b0;
          end
        end
        S_START: begin
          if (w_bitEnd) begin
            r_baudCnt <= '0;
            r_bitIdx  <= '0;
            r_state   <= S_DATA;
            r_tx      <= r_shift[0];
          end else begin
            r_baudCnt <= r_baudCnt + BW'(1);
          end
        end
        S_DATA: begin
          if (w_bitEnd) begin
            r_baudCnt <= '0;
            if (r_bitIdx == 3'd7) begin
              r_state <= S_STOP;
              r_tx    <= 1'b1;
            end else begin
              r_shift  <= {1'b0, r_shift[7:1]};
              r_bitIdx <= r_bitIdx + 3'd1;
              r_tx     <= r_shift[1];
            end
          end else begin
            r_baudCnt <= r_baudCnt + BW'(1);
          end
        end
        S_STOP: begin
          if (w_bitEnd) begin
            r_baudCnt <= '0;
            if (!w_empty) begin
              r_shift <= w_head;
              r_state <= S_START;
              r_tx    <= 1'b0;
            end else begin
              r_state <= S_IDLE;
              r_tx    <= 1'b1;
            end
          end else begin
            r_baudCnt <= r_baudCnt + BW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

  assign w_count4 = 4'(w_count);

  assign ReadData = w_stHit ? packStatus(w_full, w_empty, (r_state != S_IDLE),
                                         r_ovf, w_count4)
                            : 32'h0;
  assign TX       = r_tx;
  assign Busy     = !w_empty || (r_state != S_IDLE);

  assign w_unused = ^{ALUResult[1:0], WriteData[31:8]};

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: directed scenarios plus random
// stores, compared every cycle against a frame-timeline reference model.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          CPB   = 4;
  localparam int          DEPTH = 4;
  localparam int          FRAME = 10 * CPB;

  logic        CLK = 1'b0;
  logic        RST;
  logic        MemWrite;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        TX;
  logic        Busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: each accepted byte has the edge it was pushed on and
  // the edge its frame starts (the edge it is popped).
  int         pushE[$];
  int         startE[$];
  logic [7:0] bytesQ[$];
  logic       mOvf;

  always #5 CLK = ~CLK;

  mmio_uart_tx #(
    .BASE_ADDR    (BASE),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .MemWrite  (MemWrite),
    .ALUResult (ALUResult),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .TX        (TX),
    .Busy      (Busy)
  );

  function automatic int modelCount(input int c);
    int k = 0;
    foreach (pushE[i]) if (pushE[i] <= c && startE[i] > c) k++;
    return k;
  endfunction

  function automatic int activeFrame(input int c);
    foreach (startE[i]) if (startE[i] <= c && c < startE[i] + FRAME) return i;
    return -1;
  endfunction

  function automatic logic modelTx(input int c);
    int f;
    int bitNo;
    f = activeFrame(c);
    if (f < 0) return 1'b1;
    bitNo = (c - startE[f]) / CPB;
    if (bitNo == 0) return 1'b0;
    if (bitNo == 9) return 1'b1;
    return bytesQ[f][bitNo-1];
  endfunction

  function automatic logic modelBusy(input int c);
    return (modelCount(c) > 0) || (activeFrame(c) >= 0);
  endfunction

  function automatic logic [31:0] modelStatus(input int c);
    int k;
    logic [31:0] s;
    k = modelCount(c);
    s = 32'h0;
    s[0] = (k == DEPTH);
    s[1] = (k == 0);
    s[2] = (activeFrame(c) >= 0);
    s[3] = mOvf;
    s[7:4] = k[3:0];
    return s;
  endfunction

  // A byte pushed on edge e starts one edge later, or right after the
  // previous frame; it is dropped if the queue is full with no pop on e.
  task automatic modelPush(input int e, input logic [7:0] b);
    int  cnt;
    int  s;
    bit  popHere;
    cnt = modelCount(e - 1);
    popHere = 0;
    foreach (startE[i]) if (startE[i] == e) popHere = 1;
    if (cnt == DEPTH && !popHere) begin
      mOvf = 1'b1;
    end else begin
      s = e + 1;
      if (startE.size() > 0 && startE[$] + FRAME > s) s = startE[$] + FRAME;
      pushE.push_back(e);
      startE.push_back(s);
      bytesQ.push_back(b);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s cyc=%0d observed=%0h expected=%0h",
             tag, cyc, observed, expected);
    end
  endtask

  task automatic checkModel();
    MemWrite  = 1'b0;
    ALUResult = BASE + 32'd4;
    #1;
    checkOutput("tx",     {31'd0, TX},   {31'd0, modelTx(cyc)});
    checkOutput("busy",   {31'd0, Busy}, {31'd0, modelBusy(cyc)});
    checkOutput("status", ReadData,      modelStatus(cyc));
  endtask

  task automatic applyStimulus(input logic we, input logic [31:0] addr,
                               input logic [31:0] data);
    logic [31:0] baseV;
    logic        hit;
    baseV = BASE;
    hit   = (addr[31:3] == baseV[31:3]);
    if (we && hit && !addr[2]) modelPush(cyc + 1, data[7:0]);
    if (we && hit && addr[2] && data[3]) mOvf = 1'b0;
    MemWrite  = we;
    ALUResult = addr;
    WriteData = data;
    @(posedge CLK);
    cyc++;
    #1;
    checkModel();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, BASE + 32'd4, 32'h0);
  endtask

  task automatic resetPulse();
    RST      = 1'b1;
    MemWrite = 1'b0;
    pushE.delete();
    startE.delete();
    bytesQ.delete();
    mOvf = 1'b0;
    @(posedge CLK);
    cyc++;
    #1;
    RST = 1'b0;
    checkModel();
  endtask

  initial begin
    int e;
    int lowCnt;
    int r;

    RST = 1'b1; MemWrite = 1'b0; ALUResult = 32'h0; WriteData = 32'h0;
    mOvf = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    ALUResult = BASE + 32'd4;
    #1;
    checkOutput("rst_tx",     {31'd0, TX},   32'd1);
    checkOutput("rst_busy",   {31'd0, Busy}, 32'd0);
    checkOutput("rst_status", ReadData,      32'h2);

    // Single frame of 0xA5 with exact start latency and Busy fall time.
    applyStimulus(1'b1, BASE, 32'h0000_00A5);
    e = cyc;
    checkOutput("t1_tx_at_push", {31'd0, TX}, 32'd1);
    idle(1);
    checkOutput("t1_tx_start", {31'd0, TX}, 32'd0);
    while (cyc < e + 40) idle(1);
    checkOutput("t1_busy_last", {31'd0, Busy}, 32'd1);
    idle(1);
    checkOutput("t1_busy_fall", {31'd0, Busy}, 32'd0);

    // Four stores on consecutive edges produce contiguous frames.
    applyStimulus(1'b1, BASE, 32'h11);
    applyStimulus(1'b1, BASE, 32'h22);
    applyStimulus(1'b1, BASE, 32'h33);
    applyStimulus(1'b1, BASE, 32'h44);
    checkOutput("t2_count_peak", (ReadData >> 4) & 32'hF, 32'd3);
    idle(170);
    checkOutput("t2_busy_done", {31'd0, Busy}, 32'd0);

    // Six stores into a 4-deep FIFO: the last is dropped, overflow sticks.
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, BASE, 32'h60 + i);
    checkOutput("t3_status_ovf", ReadData, 32'h4D);
    applyStimulus(1'b1, BASE + 32'd4, 32'h8);
    checkOutput("t3_status_clr", ReadData, 32'h45);
    idle(210);

    // Out-of-window store and plain load leave the block untouched.
    applyStimulus(1'b1, BASE + 32'd8, 32'h55);
    ALUResult = BASE + 32'd8;
    #1;
    checkOutput("t4_rd_outside", ReadData,      32'h0);
    checkOutput("t4_tx_idle",    {31'd0, TX},   32'd1);
    checkOutput("t4_busy_idle",  {31'd0, Busy}, 32'd0);
    ALUResult = BASE + 32'd4;
    #1;
    checkOutput("t4_rd_status", ReadData, 32'h2);

    // Reset mid-frame with two bytes still queued.
    applyStimulus(1'b1, BASE, 32'hC3);
    e = cyc;
    applyStimulus(1'b1, BASE, 32'h3C);
    applyStimulus(1'b1, BASE, 32'h5A);
    while (cyc < e + 14) idle(1);
    resetPulse();
    checkOutput("t5_tx",     {31'd0, TX},   32'd1);
    checkOutput("t5_status", ReadData,      32'h2);
    checkOutput("t5_busy",   {31'd0, Busy}, 32'd0);
    idle(60);

    // Unaligned TXDATA address, upper data bits ignored: byte 0x00.
    applyStimulus(1'b1, BASE + 32'd3, 32'hFFFF_FF00);
    lowCnt = 0;
    for (int i = 0; i < 45; i++) begin
      idle(1);
      if (TX === 1'b0) lowCnt++;
    end
    checkOutput("t6_low_cycles", lowCnt, 32'd36);

    // Random traffic mix against the model.
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(99);
      if (r < 30)
        applyStimulus(1'b1, BASE + $urandom_range(3), $urandom);
      else if (r < 36)
        applyStimulus(1'b1, BASE + 32'd4 + $urandom_range(3), $urandom);
      else if (r < 41)
        applyStimulus(1'b1, BASE + 32'd8 + ($urandom_range(7) << 2), $urandom);
      else if (r < 42)
        resetPulse();
      else
        idle(1);
    end
    idle(300);
    checkOutput("rand_drained", {31'd0, Busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
